if_id_buffer: RTL

//  IF->ID pipeline boundary between instruction_fetch and the decode stage.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/inst_fields.sv | 19 +
 rtl/if_id_buffer.sv | 86 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core widths, NOP encoding, RISC-V field positions and opcodes
package cpu_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;
    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    localparam logic [6:0] OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OP_REG    = 7'b011_0011;
    localparam logic [6:0] OP_LUI    = 7'b011_0111;
    localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OP_SYSTEM = 7'b111_0011;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fields.sv
// inst_fields: combinational split of an instruction word into its fixed RISC-V fields
module inst_fields
    import cpu_pkg::*;
(
    input  logic [ILEN-1:0] inst,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7
);
    assign opcode = inst[OPC_MSB:OPC_LSB];
    assign rd     = inst[RD_MSB:RD_LSB];
    assign funct3 = inst[F3_MSB:F3_LSB];
    assign rs1    = inst[RS1_MSB:RS1_LSB];
    assign rs2    = inst[RS2_MSB:RS2_LSB];
    assign funct7 = inst[F7_MSB:F7_LSB];
endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: IF->ID in-order FIFO with valid/ready handshakes, flush and pre-split fields
module if_id_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_pc4,
    input  logic [ILEN-1:0]        in_inst,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_pc4,
    output logic [ILEN-1:0]        out_inst,
    output logic [6:0]             out_opcode,
    output logic [4:0]             out_rd,
    output logic [2:0]             out_funct3,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [6:0]             out_funct7,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  entry_d;
    fetch_entry_t  head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Handshakes depend on registered occupancy only; flush clears all control state
    always_comb begin
        in_ready  = count_q < CW'(DEPTH);
        out_valid = count_q != '0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        entry_d   = {in_pc, in_pc4, in_inst};
        wr_ptr_d  = flush ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d  = flush ? '0 : rd_ptr_q + PW'(pop);
        count_d   = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; a push dropped by flush does not write
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= entry_d;
    end

    // Head presentation; an empty buffer shows PC 0 and a NOP
    always_comb begin
        head     = mem_q[rd_ptr_q];
        out_pc   = out_valid ? head.pc : '0;
        out_pc4  = out_valid ? head.pc4 : '0;
        out_inst = out_valid ? head.inst : NOP_INST;
        count    = count_q;
    end

    inst_fields u_fields (
        .inst   (out_inst),
        .opcode (out_opcode),
        .rd     (out_rd),
        .funct3 (out_funct3),
        .rs1    (out_rs1),
        .rs2    (out_rs2),
        .funct7 (out_funct7)
    );
endmodule
